// File: rtl/multicycle_control.sv
// multicycle_control
//   Multi-cycle sequencing control for the RV32I core. Each instruction
//   passes through FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and shares one
//   memory port with the datapath. The unit flags illegal encodings by
//   parking in TRAP, and counts retired instructions.
//
// Parameters
//   CNT_WIDTH  width of the retired-instruction counter (instret)
//   TIMEOUT    wait cycles tolerated on mem_ready before a bus error (1..255)
//
// Optional feature (macro CTRL_MEM_WATCHDOG_EN)
//   Defined:   a wait counter watches FETCH/MEM; after TIMEOUT low cycles a
//              further low cycle sends the FSM to TRAP with bus_error set.
//   Undefined: FETCH/MEM wait indefinitely and bus_error is tied to 0.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   opcode, funct3, funct7          instruction register fields
//   branch_cond                     ALU compare result (used in EXEC)
//   mem_ready                       memory completes the access this cycle
//   mem_read, mem_write, addr_sel   memory request and address select
//   ir_write, reg_write, mem_to_reg datapath enables
//   imm_select, pc_write, pc_src    operand B / PC update control
//   jump                            JAL/JALR in progress
//   trap, bus_error                 sticky error flags (registered)
//   state                           current FSM state (debug / checkers)
//   instret                         retired-instruction counter
//
// Memory handshake: a request (mem_read or mem_write with addr_sel) is held
// asserted and unchanged every cycle the FSM sits in FETCH or MEM; the
// access completes in the first cycle where mem_ready is sampled high, and
// the FSM leaves that state on the following clock edge.

module multicycle_control #(
  parameter int CNT_WIDTH = 32,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic                 branch_cond,
  input  logic                 mem_ready,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 addr_sel,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 imm_select,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic                 jump,
  output logic                 trap,
  output logic                 bus_error,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  state_e                 state_q, state_d;
  logic                   trap_q, trap_d;
  logic [CNT_WIDTH-1:0]   instret_q;
  logic                   wd_expire;

  // Instruction class decode
  logic is_r, is_branch, is_load, is_store, is_jmp, is_fence, imm_class, illegal;

  assign is_r      = (opcode == OP_R);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_jmp    = (opcode == OP_JAL) || (opcode == OP_JALR);
  assign is_fence  = (opcode == OP_FENCE);
  // Known classes that take the immediate as operand B (unknown opcodes do not).
  assign imm_class = (opcode == OP_IMM) || (opcode == OP_LUI) || (opcode == OP_AUIPC) ||
                     is_load || is_store || is_jmp || is_fence;

  always_comb begin
    illegal = 1'b0;
    case (opcode)
      OP_R:      illegal = !((funct7 == 7'b0000000) ||
                             ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      OP_IMM: begin
        if (funct3 == 3'b001)      illegal = (funct7 != 7'b0000000);
        else if (funct3 == 3'b101) illegal = !((funct7 == 7'b0000000) || (funct7 == 7'b0100000));
      end
      OP_LOAD:   illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      OP_STORE:  illegal = (funct3 > 3'b010);
      OP_BRANCH: illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      OP_JALR:   illegal = (funct3 != 3'b000);
      OP_LUI, OP_AUIPC, OP_JAL, OP_FENCE: illegal = 1'b0;
      default:   illegal = 1'b1;   // includes SYSTEM
    endcase
  end

`ifdef CTRL_MEM_WATCHDOG_EN
  localparam logic [7:0] TO = 8'(TIMEOUT);
  logic [7:0] wait_q, wait_d;
  logic       bus_error_q, bus_error_d;

  // Fires only when the limit is reached and the access still has not completed.
  assign wd_expire = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready && (wait_q == TO);

  // Staying in FETCH/MEM implies a low mem_ready; any other path clears the count.
  always_comb begin
    wait_d = 8'd0;
    if (((state_q == S_FETCH) || (state_q == S_MEM)) && (state_d == state_q))
      wait_d = wait_q + 8'd1;
  end

  assign bus_error_d = bus_error_q | wd_expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q      <= 8'd0;
      bus_error_q <= 1'b0;
    end else begin
      wait_q      <= wait_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign bus_error = bus_error_q;
`else
  assign wd_expire = 1'b0;
  assign bus_error = 1'b0;
`endif

  // Next-state and control outputs
  always_comb begin
    state_d    = state_q;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    addr_sel   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    imm_select = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    jump       = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wd_expire) begin
          state_d  = S_TRAP;
        end
      end
      S_DECODE: begin
        imm_select = imm_class;
        state_d    = illegal ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        imm_select = imm_class;
        if (is_branch) begin
          pc_write = 1'b1;
          pc_src   = branch_cond;
          state_d  = S_FETCH;
        end else if (is_fence) begin
          pc_write = 1'b1;
          state_d  = S_FETCH;
        end else if (is_load || is_store) begin
          state_d  = S_MEM;
        end else if (is_jmp) begin
          jump     = 1'b1;
          state_d  = S_WB;
        end else begin
          state_d  = S_WB;
        end
      end
      S_MEM: begin
        imm_select = imm_class;
        addr_sel   = 1'b1;
        mem_read   = is_load;
        mem_write  = is_store;
        if (mem_ready) begin
          if (is_load) begin
            state_d  = S_WB;
          end else begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end
        end else if (wd_expire) begin
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        imm_select = imm_class;
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        mem_to_reg = is_load;
        jump       = is_jmp;
        pc_src     = is_jmp;
        state_d    = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  assign trap_d = trap_q | (state_d == S_TRAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      trap_q    <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      trap_q    <= trap_d;
      if (pc_write) instret_q <= instret_q + CNT_WIDTH'(1);
    end
  end

  assign state   = state_q;
  assign trap    = trap_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  localparam int CW = 4;
  localparam int TO = 4;

  // Control bundle bit masks: {mem_read, mem_write, addr_sel, ir_write,
  // reg_write, mem_to_reg, imm_select, pc_write, pc_src, jump}
  localparam logic [9:0] C_MR  = 10'b1000000000;
  localparam logic [9:0] C_MW  = 10'b0100000000;
  localparam logic [9:0] C_AS  = 10'b0010000000;
  localparam logic [9:0] C_IRW = 10'b0001000000;
  localparam logic [9:0] C_RW  = 10'b0000100000;
  localparam logic [9:0] C_M2R = 10'b0000010000;
  localparam logic [9:0] C_IMM = 10'b0000001000;
  localparam logic [9:0] C_PCW = 10'b0000000100;
  localparam logic [9:0] C_PCS = 10'b0000000010;
  localparam logic [9:0] C_JMP = 10'b0000000001;
  localparam logic [9:0] C_0   = 10'b0000000000;

  localparam logic [2:0] ST_I = 3'd0, ST_F = 3'd1, ST_D = 3'd2, ST_E = 3'd3,
                         ST_M = 3'd4, ST_W = 3'd5, ST_T = 3'd6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [6:0]    opcode = '0;
  logic [2:0]    funct3 = '0;
  logic [6:0]    funct7 = '0;
  logic          branch_cond = 1'b0;
  logic          mem_ready = 1'b0;
  logic          mem_read, mem_write, addr_sel, ir_write, reg_write, mem_to_reg;
  logic          imm_select, pc_write, pc_src, jump, trap, bus_error;
  logic [2:0]    state;
  logic [CW-1:0] instret;
  logic [9:0]    ctrl_obs;

  // Instruction fields applied on the next step
  logic [6:0] nx_op = '0;
  logic [2:0] nx_f3 = '0;
  logic [6:0] nx_f7 = '0;
  logic       nx_bc = 1'b0;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  logic [18:0] exp_q[$];
  logic [CW-1:0] ir_exp;

  multicycle_control #(.CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .branch_cond(branch_cond), .mem_ready(mem_ready), .mem_read(mem_read),
    .mem_write(mem_write), .addr_sel(addr_sel), .ir_write(ir_write),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .imm_select(imm_select),
    .pc_write(pc_write), .pc_src(pc_src), .jump(jump), .trap(trap),
    .bus_error(bus_error), .state(state), .instret(instret)
  );

  assign ctrl_obs = {mem_read, mem_write, addr_sel, ir_write, reg_write,
                     mem_to_reg, imm_select, pc_write, pc_src, jump};

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input logic bc);
    nx_op = op; nx_f3 = f3; nx_f7 = f7; nx_bc = bc;
  endtask

  // One clock: drive inputs 1ns after the edge, check 1ns later.
  task automatic step(input string tag, input logic rdy, input logic [2:0] st,
                      input logic [9:0] ctrl, input logic [CW-1:0] ir,
                      input logic trp, input logic be);
    logic [18:0] e;
    @(posedge clk);
    #1;
    mem_ready = rdy; opcode = nx_op; funct3 = nx_f3; funct7 = nx_f7; branch_cond = nx_bc;
    #1;
    exp_q.push_back({st, ctrl, ir, trp, be});
    e = exp_q.pop_front();
    chk({tag, ".state"}, 32'(state), 32'(e[18:16]));
    chk({tag, ".ctrl"},  32'(ctrl_obs), 32'(e[15:6]));
    chk({tag, ".stat"},  32'({instret, trap, bus_error}), 32'(e[5:0]));
  endtask

  // Asynchronous reset pulse in the middle of a cycle, checked before any edge.
  task automatic reset_pulse(input string tag);
    #1 rst_n = 1'b0;
    #1;
    chk({tag, ".rst_state"}, 32'(state), 32'(ST_I));
    chk({tag, ".rst_stat"},  32'({instret, trap, bus_error}), 32'd0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    #12;
    chk("reset.state", 32'(state), 32'(ST_I));
    chk("reset.ctrl",  32'(ctrl_obs), 32'(C_0));
    chk("reset.stat",  32'({instret, trap, bus_error}), 32'd0);
    rst_n = 1'b1;

    // ADD, zero-wait memory
    set_ir(7'b0110011, 3'b000, 7'b0000000, 1'b0);
    step("add.f", 1'b1, ST_F, C_MR | C_IRW, 4'd0, 1'b0, 1'b0);
    step("add.d", 1'b0, ST_D, C_0,          4'd0, 1'b0, 1'b0);
    step("add.e", 1'b0, ST_E, C_0,          4'd0, 1'b0, 1'b0);
    step("add.w", 1'b0, ST_W, C_RW | C_PCW, 4'd0, 1'b0, 1'b0);

    // LW: 2 fetch waits, 1 mem wait (8 cycles FETCH to FETCH)
    set_ir(7'b0000011, 3'b010, 7'b0000000, 1'b0);
    step("lw.f0", 1'b0, ST_F, C_MR,          4'd1, 1'b0, 1'b0);
    step("lw.f1", 1'b0, ST_F, C_MR,          4'd1, 1'b0, 1'b0);
    step("lw.f2", 1'b1, ST_F, C_MR | C_IRW,  4'd1, 1'b0, 1'b0);
    step("lw.d",  1'b0, ST_D, C_IMM,         4'd1, 1'b0, 1'b0);
    step("lw.e",  1'b0, ST_E, C_IMM,         4'd1, 1'b0, 1'b0);
    step("lw.m0", 1'b0, ST_M, C_MR | C_AS | C_IMM, 4'd1, 1'b0, 1'b0);
    step("lw.m1", 1'b1, ST_M, C_MR | C_AS | C_IMM, 4'd1, 1'b0, 1'b0);
    step("lw.w",  1'b0, ST_W, C_RW | C_M2R | C_IMM | C_PCW, 4'd1, 1'b0, 1'b0);

    // BEQ taken, then not taken
    set_ir(7'b1100011, 3'b000, 7'b0000000, 1'b1);
    step("beq1.f", 1'b1, ST_F, C_MR | C_IRW,  4'd2, 1'b0, 1'b0);
    step("beq1.d", 1'b0, ST_D, C_0,           4'd2, 1'b0, 1'b0);
    step("beq1.e", 1'b0, ST_E, C_PCW | C_PCS, 4'd2, 1'b0, 1'b0);
    set_ir(7'b1100011, 3'b000, 7'b0000000, 1'b0);
    step("beq0.f", 1'b1, ST_F, C_MR | C_IRW,  4'd3, 1'b0, 1'b0);
    step("beq0.d", 1'b0, ST_D, C_0,           4'd3, 1'b0, 1'b0);
    step("beq0.e", 1'b0, ST_E, C_PCW,         4'd3, 1'b0, 1'b0);

    // JAL
    set_ir(7'b1101111, 3'b000, 7'b0000000, 1'b0);
    step("jal.f", 1'b1, ST_F, C_MR | C_IRW,  4'd4, 1'b0, 1'b0);
    step("jal.d", 1'b0, ST_D, C_IMM,         4'd4, 1'b0, 1'b0);
    step("jal.e", 1'b0, ST_E, C_IMM | C_JMP, 4'd4, 1'b0, 1'b0);
    step("jal.w", 1'b0, ST_W, C_RW | C_IMM | C_PCW | C_PCS | C_JMP, 4'd4, 1'b0, 1'b0);

    // SW: ready arrives exactly at the wait limit -> completes normally
    set_ir(7'b0100011, 3'b010, 7'b0000000, 1'b0);
    step("sw.f", 1'b1, ST_F, C_MR | C_IRW, 4'd5, 1'b0, 1'b0);
    step("sw.d", 1'b0, ST_D, C_IMM,        4'd5, 1'b0, 1'b0);
    step("sw.e", 1'b0, ST_E, C_IMM,        4'd5, 1'b0, 1'b0);
    for (int i = 0; i < TO; i++)
      step("sw.mwait", 1'b0, ST_M, C_MW | C_AS | C_IMM, 4'd5, 1'b0, 1'b0);
    step("sw.mdone", 1'b1, ST_M, C_MW | C_AS | C_IMM | C_PCW, 4'd5, 1'b0, 1'b0);

    // 17 FENCEs: 4-bit instret wraps (6 + 17 = 23 -> 7)
    ir_exp = 4'd6;
    set_ir(7'b0001111, 3'b000, 7'b0000000, 1'b0);
    for (int i = 0; i < 17; i++) begin
      step("fence.f", 1'b1, ST_F, C_MR | C_IRW,  ir_exp, 1'b0, 1'b0);
      step("fence.d", 1'b0, ST_D, C_IMM,         ir_exp, 1'b0, 1'b0);
      step("fence.e", 1'b0, ST_E, C_IMM | C_PCW, ir_exp, 1'b0, 1'b0);
      ir_exp = ir_exp + 4'd1;
    end

    // LW interrupted by asynchronous reset mid-MEM
    set_ir(7'b0000011, 3'b010, 7'b0000000, 1'b0);
    step("lwr.f", 1'b1, ST_F, C_MR | C_IRW, 4'd7, 1'b0, 1'b0);
    step("lwr.d", 1'b0, ST_D, C_IMM,        4'd7, 1'b0, 1'b0);
    step("lwr.e", 1'b0, ST_E, C_IMM,        4'd7, 1'b0, 1'b0);
    step("lwr.m", 1'b0, ST_M, C_MR | C_AS | C_IMM, 4'd7, 1'b0, 1'b0);
    reset_pulse("lwr");

    // One FENCE so the trap below has a non-zero count to preserve
    set_ir(7'b0001111, 3'b000, 7'b0000000, 1'b0);
    step("fn.f", 1'b1, ST_F, C_MR | C_IRW,  4'd0, 1'b0, 1'b0);
    step("fn.d", 1'b0, ST_D, C_IMM,         4'd0, 1'b0, 1'b0);
    step("fn.e", 1'b0, ST_E, C_IMM | C_PCW, 4'd0, 1'b0, 1'b0);

    // R-type with funct7 = 0000001 -> TRAP, sticky until reset
    set_ir(7'b0110011, 3'b000, 7'b0000001, 1'b0);
    step("ill_r.f",  1'b1, ST_F, C_MR | C_IRW, 4'd1, 1'b0, 1'b0);
    step("ill_r.d",  1'b0, ST_D, C_0,          4'd1, 1'b0, 1'b0);
    step("ill_r.t0", 1'b1, ST_T, C_0,          4'd1, 1'b1, 1'b0);
    step("ill_r.t1", 1'b1, ST_T, C_0,          4'd1, 1'b1, 1'b0);
    step("ill_r.t2", 1'b1, ST_T, C_0,          4'd1, 1'b1, 1'b0);
    reset_pulse("ill_r");

    // SYSTEM opcode -> TRAP
    set_ir(7'b1110011, 3'b000, 7'b0000000, 1'b0);
    step("sys.f",  1'b1, ST_F, C_MR | C_IRW, 4'd0, 1'b0, 1'b0);
    step("sys.d",  1'b0, ST_D, C_0,          4'd0, 1'b0, 1'b0);
    step("sys.t0", 1'b1, ST_T, C_0,          4'd0, 1'b1, 1'b0);
    step("sys.t1", 1'b1, ST_T, C_0,          4'd0, 1'b1, 1'b0);
    reset_pulse("sys");

    // Load with funct3 = 011 -> TRAP
    set_ir(7'b0000011, 3'b011, 7'b0000000, 1'b0);
    step("ill_ld.f", 1'b1, ST_F, C_MR | C_IRW, 4'd0, 1'b0, 1'b0);
    step("ill_ld.d", 1'b0, ST_D, C_IMM,        4'd0, 1'b0, 1'b0);
    step("ill_ld.t", 1'b1, ST_T, C_0,          4'd0, 1'b1, 1'b0);
    reset_pulse("ill_ld");

    // SW with mem_ready held low in MEM
    set_ir(7'b0100011, 3'b010, 7'b0000000, 1'b0);
    step("swt.f", 1'b1, ST_F, C_MR | C_IRW, 4'd0, 1'b0, 1'b0);
    step("swt.d", 1'b0, ST_D, C_IMM,        4'd0, 1'b0, 1'b0);
    step("swt.e", 1'b0, ST_E, C_IMM,        4'd0, 1'b0, 1'b0);
`ifdef CTRL_MEM_WATCHDOG_EN
    for (int i = 0; i <= TO; i++)
      step("swt.mwait", 1'b0, ST_M, C_MW | C_AS | C_IMM, 4'd0, 1'b0, 1'b0);
    step("swt.t0", 1'b0, ST_T, C_0, 4'd0, 1'b1, 1'b1);
    step("swt.t1", 1'b1, ST_T, C_0, 4'd0, 1'b1, 1'b1);
    reset_pulse("swt");
`else
    for (int i = 0; i < 12; i++)
      step("swt.mwait", 1'b0, ST_M, C_MW | C_AS | C_IMM, 4'd0, 1'b0, 1'b0);
    step("swt.mdone", 1'b1, ST_M, C_MW | C_AS | C_IMM | C_PCW, 4'd0, 1'b0, 1'b0);
    set_ir(7'b0010011, 3'b000, 7'b0000000, 1'b0);
    step("addi.f", 1'b1, ST_F, C_MR | C_IRW, 4'd1, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencing control unit for the RV32I core, the successor to the single-cycle combinational decoder. It steps each instruction through fetch, decode, execute, memory and write-back states over a single shared memory port with a ready handshake. It also detects illegal encodings, includes an optional memory-wait watchdog, and counts retired instructions. It sits between the instruction register / ALU compare logic and the datapath enables.

## Interface
- CNT_WIDTH, 32: width of the retired-instruction counter.
- TIMEOUT, 15: maximum wait cycles on mem_ready before a bus error (range 1..255).

- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  from IR, stable from DECODE until the next FETCH.
- funct3  in  3  from IR.
- funct7  in  7  from IR.
- branch_cond  in  1  ALU compare result, valid in EXEC.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_read  out  1  memory read request (fetch or load).
- mem_write  out  1  memory write request (store).
- addr_sel  out  1  0 = PC address, 1 = ALU address.
- ir_write  out  1  load IR with the fetched word.
- reg_write  out  1  register file write enable.
- mem_to_reg  out  1  write-back source is memory data.
- imm_select  out  1  ALU operand B is the immediate.
- pc_write  out  1  update PC.
- pc_src  out  1  0 = PC+4, 1 = branch/jump target.
- jump  out  1  JAL/JALR in progress (write-back data = PC+4).
- trap  out  1  sticky; set on an illegal instruction or bus error.
- bus_error  out  1  sticky; set on a watchdog expiry.
- state  out  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- instret  out  CNT_WIDTH  retired-instruction count.

## Operation
- Reset puts the block in IDLE. In IDLE all outputs are 0, instret is 0 and state is 0. IDLE moves to FETCH unconditionally on the next clock.
- FETCH: mem_read=1, addr_sel=0. When mem_ready is seen, ir_write=1 that same cycle and the next state is DECODE.
- DECODE checks the encoding. An illegal encoding goes to TRAP; anything else goes to EXEC. The following are illegal:
  - an unknown opcode, including SYSTEM (1110011);
  - R-type with funct7 other than 0000000, or 0100000 with funct3 other than 000/101;
  - OP-IMM shifts: funct3 001 requires funct7=0; funct3 101 requires funct7 of 0 or 0100000;
  - a load with funct3 in {011,110,111};
  - a store with funct3 greater than 010;
  - a branch with funct3 in {010,011};
  - JALR with funct3 not equal to 000.
- imm_select=1 from DECODE through WB for every class except R-type and branch. For branch, imm_select=0 so rs1 is compared with rs2.
- EXEC routes by instruction class:
  - R-type, OP-IMM, LUI, AUIPC: go to WB.
  - Load, store: go to MEM.
  - Branch: pc_write=1 and pc_src=branch_cond, then go to FETCH (retire).
  - JAL, JALR: jump=1, go to WB.
  - FENCE (0001111): pc_write=1, pc_src=0, go to FETCH (retire, no-op).
- MEM: addr_sel=1, with mem_read=1 for a load or mem_write=1 for a store. When mem_ready is seen, a load goes to WB. A store sets pc_write=1, pc_src=0 and goes to FETCH (retire).
- WB: reg_write=1 and pc_write=1, then go to FETCH (retire).
  - Load: mem_to_reg=1.
  - JAL/JALR: jump=1, pc_src=1.
  - All others: pc_src=0.
- TRAP: trap=1 and all enables are 0. The block stays in TRAP until reset.
- instret increments by 1 in every cycle where pc_write=1 and wraps modulo 2^CNT_WIDTH. A trapping instruction never increments it.
- All control outputs are combinational decodes of the registered state and the IR fields. state, trap, bus_error and instret are registers.

## Timing
- Latency with zero-wait memory (mem_ready high in the request cycle):
  - branch and FENCE: 3 cycles;
  - ALU, LUI, AUIPC, JAL, JALR, store: 4 cycles;
  - load: 5 cycles.
- Each wait cycle with mem_ready low extends FETCH or MEM by one cycle. The request stays asserted and unchanged while waiting.
- pc_write is high for exactly one cycle per retired instruction. ir_write is high for exactly one cycle per fetch.
- An asynchronous reset at any point, including mid-MEM, immediately forces IDLE and clears instret, trap and bus_error.

## Configuration
- CTRL_MEM_WATCHDOG_EN defined: a wait counter clears on entry to FETCH or MEM and increments each cycle that mem_ready is low. When the counter reaches TIMEOUT with mem_ready still low, the next state is TRAP and bus_error=1 and trap=1. If mem_ready arrives in the same cycle as the limit, the access completes normally and there is no error.
- CTRL_MEM_WATCHDOG_EN undefined: no counter exists, FETCH/MEM wait indefinitely, and bus_error is tied to 0.

## Test plan
- Reset, then ADD (0110011/000/0000000) with mem_ready held at 1: state sequence 0,1,2,3,5,1. reg_write and pc_write are high only in WB. instret becomes 1.
- LW (0000011/010) with 2 wait cycles in FETCH and 1 in MEM: 8 cycles from FETCH entry to return to FETCH. mem_to_reg=1 in WB and addr_sel=1 in MEM.
- BEQ with branch_cond=1, then again with branch_cond=0: pc_write in EXEC with pc_src=1 and then 0. instret increments by 2 and there is no WB state.
- funct7=0000001 on R-type, and separately SYSTEM 1110011: state goes to 6 after DECODE. trap=1, instret is unchanged, and the block stays in TRAP until rst_n is pulsed.
- With CTRL_MEM_WATCHDOG_EN and TIMEOUT=4: mem_ready held at 0 in MEM goes to TRAP with bus_error=1. A second run with mem_ready rising exactly at the limit completes the SW with no error.
- CNT_WIDTH=4 with 17 FENCE instructions: instret wraps to 1. Asserting rst_n low mid-MEM returns state to 0 and instret to 0 asynchronously.
